// File: rtl/fifo_stream_arbiter_if.sv
// Bundle of producer-side and consumer-side stream signals for fifo_stream_arbiter.
// Handshake: a word moves on a clock edge where its empty flag is low and its pop strobe is high
// (IN_EMPTY/IN_READ per source, FIFO_EMPTY/FIFO_READ at the output); the data is valid whenever the empty flag is low.
interface fifo_stream_arbiter_if #(
  parameter int N  = 2,
  parameter int DW = 32
);
  logic [N-1:0]    IN_EMPTY;
  logic [N*DW-1:0] IN_DATA;
  logic [N-1:0]    IN_READ;
  logic            FIFO_READ;
  logic            FIFO_EMPTY;
  logic [DW-1:0]   FIFO_DATA;
  logic [2:0]      GRANT;
  logic            READ_ERROR;
  logic [31:0]     WORD_CNT;
  logic            DBG_STATE;

  modport slave (
    input  IN_EMPTY, IN_DATA, FIFO_READ,
    output IN_READ, FIFO_EMPTY, FIFO_DATA, GRANT, READ_ERROR, WORD_CNT, DBG_STATE
  );

  modport master (
    output IN_EMPTY, IN_DATA, FIFO_READ,
    input  IN_READ, FIFO_EMPTY, FIFO_DATA, GRANT, READ_ERROR, WORD_CNT, DBG_STATE
  );
endinterface

// File: rtl/fifo_stream_arbiter.sv
// Round-robin merge of N first-word-fall-through streams with burst lock and one registered output word.
// DBG_STATE exposes the FSM state (0 = IDLE, 1 = LOCKED).
module fifo_stream_arbiter #(
  parameter int N         = 2,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input logic                BUS_CLK,
  input logic                BUS_RST_N,
  fifo_stream_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q;
  logic [2:0]      grant_q;
  logic [2:0]      last_q;
  logic [31:0]     cnt_q;
  logic            fifo_empty_q;
  logic [DW-1:0]   fifo_data_q;
  logic            read_error_q;
  logic [31:0]     word_cnt_q;

  logic            accept;
  logic            gnt_empty;
  logic [DW-1:0]   gnt_data;
  logic            pop;
  logic            deliver;
  logic [N-1:0]    in_read;
  logic            found;
  logic [2:0]      pick;
  logic [31:0]     cnt_d;
  logic [31:0]     word_cnt_d;

  always_comb begin
    accept    = fifo_empty_q | bus.FIFO_READ;
    deliver   = bus.FIFO_READ & ~fifo_empty_q;
    gnt_empty = 1'b1;
    gnt_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == 3'(i)) begin
        gnt_empty = bus.IN_EMPTY[i];
        gnt_data  = bus.IN_DATA[i*DW +: DW];
      end
    end
    pop     = (state_q == LOCKED) && !gnt_empty && accept;
    in_read = '0;
    for (int i = 0; i < N; i++) begin
      in_read[i] = pop && (grant_q == 3'(i));
    end
    // Scan starts one past the last granted source, so every active source gets a turn.
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (((int'(last_q) + k) % N) == i) && !bus.IN_EMPTY[i]) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
    cnt_d      = cnt_q + 32'd1;
    word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= 3'(N - 1);
      cnt_q        <= '0;
      fifo_empty_q <= 1'b1;
      fifo_data_q  <= '0;
      read_error_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      read_error_q <= bus.FIFO_READ & fifo_empty_q;
      if (deliver) begin
        word_cnt_q <= word_cnt_d;
      end
      // A pop in the same cycle as a consumer read replaces the word without a bubble.
      if (pop) begin
        fifo_data_q  <= gnt_data;
        fifo_empty_q <= 1'b0;
      end else if (deliver) begin
        fifo_empty_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            cnt_q   <= '0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (pop) begin
            cnt_q <= cnt_d;
            if ((MAX_BURST != 0) && (cnt_d == 32'(MAX_BURST))) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end
          end else if (gnt_empty) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IN_READ    = in_read;
  assign bus.FIFO_EMPTY = fifo_empty_q;
  assign bus.FIFO_DATA  = fifo_data_q;
  assign bus.GRANT      = grant_q;
  assign bus.READ_ERROR = read_error_q;
  assign bus.WORD_CNT   = word_cnt_q;
  assign bus.DBG_STATE  = state_q;

endmodule

// File: tb/tb_fifo_stream_arbiter.sv
// Directed bench for fifo_stream_arbiter: two DUTs (MAX_BURST=4 and MAX_BURST=0) share the stimulus,
// queue-based source models feed them and a scoreboard checks the merged word order.
module tb_fifo_stream_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_empty;
  logic [63:0] in_data;
  logic        fifo_read;
  logic        sel;

  fifo_stream_arbiter_if #(.N(2), .DW(32)) b0 ();
  fifo_stream_arbiter_if #(.N(2), .DW(32)) b1 ();

  assign b0.IN_EMPTY  = in_empty;
  assign b0.IN_DATA   = in_data;
  assign b0.FIFO_READ = fifo_read;
  assign b1.IN_EMPTY  = in_empty;
  assign b1.IN_DATA   = in_data;
  assign b1.FIFO_READ = fifo_read;

  fifo_stream_arbiter #(.N(2), .DW(32), .MAX_BURST(4)) u_dut0 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .bus(b0)
  );
  fifo_stream_arbiter #(.N(2), .DW(32), .MAX_BURST(0)) u_dut1 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .bus(b1)
  );

  logic [1:0]  o_in_read;
  logic        o_fifo_empty;
  logic [31:0] o_fifo_data;
  logic [2:0]  o_grant;
  logic        o_read_error;
  logic [31:0] o_word_cnt;
  logic        o_state;

  assign o_in_read    = sel ? b1.IN_READ    : b0.IN_READ;
  assign o_fifo_empty = sel ? b1.FIFO_EMPTY : b0.FIFO_EMPTY;
  assign o_fifo_data  = sel ? b1.FIFO_DATA  : b0.FIFO_DATA;
  assign o_grant      = sel ? b1.GRANT      : b0.GRANT;
  assign o_read_error = sel ? b1.READ_ERROR : b0.READ_ERROR;
  assign o_word_cnt   = sel ? b1.WORD_CNT   : b0.WORD_CNT;
  assign o_state      = sel ? b1.DBG_STATE  : b0.DBG_STATE;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [31:0] src_q0[$];
  logic [31:0] src_q1[$];
  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_err;
  int          n_consumed;
  int          cyc;
  int          first_cyc;
  logic        cons_en;
  logic        force_rd;

  logic [1:0]  s_in_read;
  logic        s_empty;
  logic [31:0] s_data;
  logic [2:0]  s_grant;
  logic        s_rerr;
  logic        s_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_srcs();
    in_empty[0]     = (src_q0.size() == 0);
    in_empty[1]     = (src_q1.size() == 0);
    in_data[31:0]   = in_empty[0] ? 32'd0 : src_q0[0];
    in_data[63:32]  = in_empty[1] ? 32'd0 : src_q1[0];
  endtask

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    drive_srcs();
    fifo_read = force_rd | (cons_en & ~o_fifo_empty);
    #1;
    s_in_read = o_in_read;
    s_empty   = o_fifo_empty;
    s_data    = o_fifo_data;
    s_grant   = o_grant;
    s_rerr    = o_read_error;
    s_state   = o_state;
    check("in_read_onehot", 32'($countones(s_in_read) <= 1), 32'd1);
    if (!s_empty && first_cyc == 0) first_cyc = cyc;
    if (fifo_read && !s_empty) begin
      n_consumed++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("sb_data", s_data, e);
    end
    @(posedge clk);
    #1;
    if (s_in_read[0] && src_q0.size() != 0) void'(src_q0.pop_front());
    if (s_in_read[1] && src_q1.size() != 0) void'(src_q1.pop_front());
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q0.delete();
    src_q1.delete();
    exp_q.delete();
    cons_en    = 1'b1;
    force_rd   = 1'b0;
    fifo_read  = 1'b0;
    n_consumed = 0;
    first_cyc  = 0;
    cyc        = 0;
    drive_srcs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(o_fifo_empty), 32'd1);
    check({tag, "_data"},  o_fifo_data, 32'd0);
    check({tag, "_grant"}, 32'(o_grant), 32'd0);
    check({tag, "_rerr"},  32'(o_read_error), 32'd0);
    check({tag, "_wcnt"},  o_word_cnt, 32'd0);
    check({tag, "_state"}, 32'(o_state), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    sel      = 1'b0;

    // reset values, both DUTs
    do_reset();
    #1;
    check_reset_outputs("rst0");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst1");
    sel = 1'b0;

    // T1: single source, three words
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src_q0.push_back(32'hA0 + 32'(i));
      exp_q.push_back(32'hA0 + 32'(i));
    end
    drain(20);
    check("t1_latency", 32'(first_cyc), 32'd3);
    check("t1_wcnt", o_word_cnt, 32'd3);
    repeat (2) tick();
    check("t1_idle", 32'(o_state), 32'd0);

    // T2: burst of four, alternating sources
    do_reset();
    for (int i = 0; i < 10; i++) begin
      src_q0.push_back(32'h00 + 32'(i));
      src_q1.push_back(32'h10 + 32'(i));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00 + 32'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h10 + 32'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(32'h00 + 32'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(32'h10 + 32'(i));
    exp_q.push_back(32'h08);
    exp_q.push_back(32'h09);
    exp_q.push_back(32'h18);
    exp_q.push_back(32'h19);
    drain(80);
    check("t2_wcnt", o_word_cnt, 32'd20);

    // T3: consumer stall mid-burst
    do_reset();
    for (int i = 0; i < 8; i++) begin
      src_q0.push_back(32'h30 + 32'(i));
      exp_q.push_back(32'h30 + 32'(i));
    end
    for (int b = 0; b < 20 && n_consumed < 2; b++) tick();
    check("t3_pre_consumed", 32'(n_consumed), 32'd2);
    cons_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_data", s_data, 32'h32);
      check("t3_hold_empty", 32'(s_empty), 32'd0);
      check("t3_in_read", 32'(s_in_read), 32'd0);
      check("t3_grant", 32'(s_grant), 32'd0);
    end
    cons_en = 1'b1;
    drain(30);
    check("t3_wcnt", o_word_cnt, 32'd8);

    // T4: read while empty
    do_reset();
    force_rd = 1'b1;
    tick();
    check("t4_rerr_before", 32'(s_rerr), 32'd0);
    force_rd = 1'b0;
    tick();
    check("t4_rerr_pulse", 32'(s_rerr), 32'd1);
    check("t4_empty", 32'(s_empty), 32'd1);
    check("t4_wcnt", o_word_cnt, 32'd0);
    tick();
    check("t4_rerr_drop", 32'(s_rerr), 32'd0);

    // T5: asynchronous reset while src1 word 2 is held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q1.push_back(32'h50 + 32'(i));
      exp_q.push_back(32'h50 + 32'(i));
    end
    for (int b = 0; b < 20 && n_consumed < 2; b++) tick();
    check("t5_pre_data", o_fifo_data, 32'h52);
    check("t5_pre_grant", 32'(o_grant), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    src_q0.push_back(32'h60);
    exp_q.delete();
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h53);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_regrant", 32'(o_grant), 32'd0);
    check("t5_locked", 32'(o_state), 32'd1);
    drain(20);
    check("t5_wcnt", o_word_cnt, 32'd2);

    // T6: unlimited burst and word counter wrap
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      src_q0.push_back(32'h1000 + 32'(i));
      exp_q.push_back(32'h1000 + 32'(i));
    end
    src_q1.push_back(32'h2000);
    exp_q.push_back(32'h2000);
    drain(300);
    check("t6_wcnt", o_word_cnt, 32'd101);
    force u_dut1.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut1.word_cnt_q;
    for (int i = 0; i < 3; i++) begin
      src_q0.push_back(32'h3000 + 32'(i));
      exp_q.push_back(32'h3000 + 32'(i));
    end
    drain(30);
    check("t6_wrap", o_word_cnt, 32'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
